scan_doubler: RTL and testbench

- Downstream consumer of the horizontal/vertical timing generator's pixel stream: oRGB, HBLK, VBLK, HSYN and VSYN at the 15 kHz pixel enable.
- Re-emits each input line twice at double pixel rate, giving 31 kHz VGA-class timing with an optional darkened-scanline effect.
- Uses a ping-pong pair of line buffers: one bank is written at PCLK_EN while the other is read at DCLK_EN.

---
 rtl/scan_doubler_pkg.sv | 31 +++
 rtl/line_bank_ram.sv | 25 ++
 rtl/scan_doubler.sv | 148 ++++++++++++++
 tb/tb_scan_doubler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_doubler_pkg.sv
// Shared video-timing constants for the 15 kHz -> 31 kHz line doubler.
// Colour layout is three 5-bit channels packed R:G:B, MSB first.
package scan_doubler_pkg;

  localparam int CW   = 15;
  localparam int AW   = 9;
  localparam int HW   = 6;
  localparam int CH_W = 5;
  localparam int R_LO = 10;
  localparam int G_LO = 5;
  localparam int B_LO = 0;

  localparam logic [HW-1:0] HSW_MAX = 6'd63;

  typedef struct packed {
    logic          hblk;
    logic [CW-1:0] rgb;
  } lb_word_t;

  function automatic logic [CW-1:0] half_rgb(
    input logic [CW-1:0] c
  );
    logic [CW-1:0] h;
    h = '0;
    h[R_LO +: CH_W] = c[R_LO +: CH_W] >> 1;
    h[G_LO +: CH_W] = c[G_LO +: CH_W] >> 1;
    h[B_LO +: CH_W] = c[B_LO +: CH_W] >> 1;
    return h;
  endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Ping-pong line store: two banks of 2^AW words, bank select is the
// top address bit. One write port, one registered read port.
module line_bank_ram
  import scan_doubler_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_we,
  input  logic [AW:0] i_waddr,
  input  logic [CW:0] i_wdata,
  input  logic        i_re,
  input  logic [AW:0] i_raddr,
  output logic [CW:0] o_rdata
);

  logic [CW:0] r_mem [0:(2**(AW+1))-1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/scan_doubler.sv
// Line doubler: writes each input line into one bank at PCLK_EN and
// replays the other bank twice at DCLK_EN, optionally dimming replica 2.
module scan_doubler
  import scan_doubler_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          PCLK_EN,
  input  logic          DCLK_EN,
  input  logic [CW-1:0] iRGB,
  input  logic          iHBLK,
  input  logic          iVBLK,
  input  logic          iHSYN,
  input  logic          iVSYN,
  input  logic          SCANLINE,
  output logic [CW-1:0] oRGB,
  output logic          oHBLK,
  output logic          oVBLK,
  output logic          oHSYN,
  output logic          oVSYN
);

  logic          r_hsyn_p;
  logic [AW-1:0] r_wx;
  logic          r_wsel;
  logic [HW-1:0] r_hsw;
  logic [HW-1:0] r_hsyncw;
  logic [AW:0]   r_llen;
  logic          r_vblk_line;
  logic          r_vsyn_line;
  logic          r_pend;
  logic [AW-1:0] r_rx;
  logic [AW-1:0] r_rx_d1;
  logic          r_rep;
  logic          r_rep_d1;
  logic          r_vblk_ln;
  logic          r_vsyn_ln;
  logic          r_vblk_d1;
  logic          r_vsyn_d1;

  logic          w_fall;
  logic          w_wbank;
  logic [AW-1:0] w_wx_nx;
  logic [AW:0]   w_eff;
  logic          w_rx_last;
  logic          w_we;
  logic [AW:0]   w_waddr;
  logic [AW:0]   w_raddr;
  lb_word_t      w_wdata;
  lb_word_t      w_rdata;

  assign w_fall    = PCLK_EN & r_hsyn_p & ~iHSYN;
  assign w_wbank   = r_wsel ^ w_fall;
  // wx holds the last written address; it sticks at the top word
  assign w_wx_nx   = w_fall ? '0
                   : (&r_wx) ? r_wx
                   : r_wx + 1'b1;
  assign w_eff     = (r_llen == '0) ? {1'b1, {AW{1'b0}}} : r_llen;
  assign w_rx_last = ({1'b0, r_rx} == w_eff - 1'b1);
  assign w_we      = PCLK_EN & ~RESET;
  assign w_waddr   = {w_wbank, w_wx_nx};
  assign w_raddr   = {~r_wsel, r_rx};
  assign w_wdata   = {iHBLK, iRGB};

  line_bank_ram u_ram (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (DCLK_EN),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hsyn_p    <= 1'b0;
      r_wx        <= '0;
      r_wsel      <= 1'b0;
      r_hsw       <= '0;
      r_hsyncw    <= '0;
      r_llen      <= '0;
      r_vblk_line <= 1'b1;
      r_vsyn_line <= 1'b1;
    end else if (PCLK_EN) begin
      r_hsyn_p <= iHSYN;
      r_wx     <= w_wx_nx;
      r_wsel   <= w_wbank;
      if (w_fall) begin
        r_llen      <= {1'b0, r_wx} + 1'b1;
        r_hsyncw    <= r_hsw;
        r_hsw       <= 6'd1;
        r_vblk_line <= iVBLK;
        r_vsyn_line <= iVSYN;
      end else if (!iHSYN && r_hsw != HSW_MAX) begin
        r_hsw <= r_hsw + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)        r_pend <= 1'b0;
    else if (w_fall)  r_pend <= 1'b1;
    else if (DCLK_EN) r_pend <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rx      <= '0;
      r_rep     <= 1'b0;
      r_vblk_ln <= 1'b1;
      r_vsyn_ln <= 1'b1;
      r_rx_d1   <= '0;
      r_rep_d1  <= 1'b0;
      r_vblk_d1 <= 1'b1;
      r_vsyn_d1 <= 1'b1;
      oRGB      <= '0;
      oHBLK     <= 1'b1;
      oVBLK     <= 1'b1;
      oHSYN     <= 1'b1;
      oVSYN     <= 1'b1;
    end else if (DCLK_EN) begin
      r_rx_d1   <= r_rx;
      r_rep_d1  <= r_rep;
      r_vblk_d1 <= r_vblk_ln;
      r_vsyn_d1 <= r_vsyn_ln;
      oRGB      <= (SCANLINE && r_rep_d1) ? half_rgb(w_rdata.rgb)
                                          : w_rdata.rgb;
      oHBLK     <= w_rdata.hblk;
      oHSYN     <= (r_rx_d1 < AW'(r_hsyncw)) ? 1'b0 : 1'b1;
      oVBLK     <= r_vblk_d1;
      oVSYN     <= r_vsyn_d1;
      // rep is sticky so a late resync keeps replaying replica 2
      if (r_pend) begin
        r_rx      <= '0;
        r_rep     <= 1'b0;
        r_vblk_ln <= r_vblk_line;
        r_vsyn_ln <= r_vsyn_line;
      end else if (w_rx_last) begin
        r_rx  <= '0;
        r_rep <= 1'b1;
      end else begin
        r_rx <= r_rx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_doubler.sv
// Randomised bench for scan_doubler against a line-level reference
// model: completed input lines are replayed twice per output line.
module tb_scan_doubler;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PCLK_EN;
  logic        DCLK_EN;
  logic [14:0] iRGB;
  logic        iHBLK;
  logic        iVBLK;
  logic        iHSYN;
  logic        iVSYN;
  logic        SCANLINE;
  logic [14:0] oRGB;
  logic        oHBLK;
  logic        oVBLK;
  logic        oHSYN;
  logic        oVSYN;

  scan_doubler dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .PCLK_EN  (PCLK_EN),
    .DCLK_EN  (DCLK_EN),
    .iRGB     (iRGB),
    .iHBLK    (iHBLK),
    .iVBLK    (iVBLK),
    .iHSYN    (iHSYN),
    .iVSYN    (iVSYN),
    .SCANLINE (SCANLINE),
    .oRGB     (oRGB),
    .oHBLK    (oHBLK),
    .oVBLK    (oVBLK),
    .oHSYN    (oHSYN),
    .oVSYN    (oVSYN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          ok;
    bit          hs_ok;
    bit          rep;
    logic [15:0] w;
    bit          hsyn;
    bit          vblk;
    bit          vsyn;
  } item_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit coin  = 1'b0;

  bit          m_phs;
  int          wr_n, wr_low;
  bit          wr_valid;
  logic [15:0] wr_pix [512];
  logic [15:0] done_pix [512];
  bit          done_valid;
  int          done_hsw;
  logic [15:0] disp_pix [512];
  bit          disp_valid;
  int          disp_hsw;
  int          m_len, m_rx;
  bit          m_rep, m_pend;
  bit          m_vbl_line, m_vsy_line, m_vbl_out, m_vsy_out;
  item_t       q [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] dim(input logic [14:0] c);
    int r, g, b;
    r = int'(c) / 1024;
    g = (int'(c) / 32) % 32;
    b = int'(c) % 32;
    return 15'((r / 2) * 1024 + (g / 2) * 32 + b / 2);
  endfunction

  task automatic model_reset();
    item_t z;
    z = '{ok: 0, hs_ok: 0, rep: 0, w: '0, hsyn: 1, vblk: 1, vsyn: 1};
    q.delete();
    q.push_back(z);
    m_phs      = 0;
    wr_n       = 1;
    wr_low     = 0;
    wr_valid   = 0;
    done_valid = 0;
    done_hsw   = 0;
    disp_valid = 0;
    disp_hsw   = 0;
    m_len      = 512;
    m_rx       = 0;
    m_rep      = 0;
    m_pend     = 0;
    m_vbl_line = 1;
    m_vsy_line = 1;
    m_vbl_out  = 1;
    m_vsy_out  = 1;
  endtask

  task automatic model_step();
    bit          fall;
    item_t       it, nw;
    logic [14:0] erg;
    if (RESET) begin
      check("rst_rgb", 32'(oRGB), 0);
      check("rst_hblk", 32'(oHBLK), 1);
      check("rst_vblk", 32'(oVBLK), 1);
      check("rst_hsyn", 32'(oHSYN), 1);
      check("rst_vsyn", 32'(oVSYN), 1);
      model_reset();
      return;
    end
    fall = PCLK_EN && m_phs && !iHSYN;
    if (DCLK_EN) begin
      nw.ok    = disp_valid && !m_pend && !fall;
      nw.hs_ok = nw.ok;
      nw.rep   = m_rep;
      nw.w     = disp_pix[m_rx];
      nw.hsyn  = (m_rx >= disp_hsw);
      nw.vblk  = m_vbl_out;
      nw.vsyn  = m_vsy_out;
      it = q.pop_front();
      q.push_back(nw);
      if (it.ok) begin
        erg = (SCANLINE && it.rep) ? dim(it.w[14:0]) : it.w[14:0];
        check("rgb", 32'(oRGB), 32'(erg));
        check("hblk", 32'(oHBLK), 32'(it.w[15]));
      end
      if (it.hs_ok) check("hsyn", 32'(oHSYN), 32'(it.hsyn));
      check("vblk", 32'(oVBLK), 32'(it.vblk));
      check("vsyn", 32'(oVSYN), 32'(it.vsyn));
      if (m_pend) begin
        m_rx       = 0;
        m_rep      = 0;
        m_pend     = 0;
        disp_pix   = done_pix;
        disp_valid = done_valid;
        disp_hsw   = done_hsw;
        m_vbl_out  = m_vbl_line;
        m_vsy_out  = m_vsy_line;
      end else if (m_rx == m_len - 1) begin
        m_rx  = 0;
        m_rep = 1;
      end else begin
        m_rx = (m_rx + 1) % 512;
      end
    end
    if (PCLK_EN) begin
      if (fall) begin
        done_pix   = wr_pix;
        done_valid = wr_valid;
        done_hsw   = wr_low;
        m_len      = wr_n;
        m_vbl_line = iVBLK;
        m_vsy_line = iVSYN;
        m_pend     = 1;
        foreach (q[i]) q[i].hs_ok = 0;
        wr_valid   = 1;
        wr_n       = 1;
        wr_low     = 1;
        wr_pix[0]  = {iHBLK, iRGB};
      end else begin
        if (wr_n < 512) begin
          wr_pix[wr_n] = {iHBLK, iRGB};
          wr_n++;
        end else begin
          wr_pix[511] = {iHBLK, iRGB};
        end
        if (!iHSYN && wr_low < 63) wr_low++;
      end
      m_phs = iHSYN;
    end
  endtask

  task automatic tick();
    PCLK_EN = (cyc % 4 == 0);
    DCLK_EN = coin ? (cyc % 2 == 0) : (cyc % 2 == 1);
    @(posedge CLK);
    #1;
    model_step();
    cyc++;
  endtask

  task automatic run_line(input int len, input int hs, input int mode,
                          input bit vb, input bit vs, input int rst_at);
    for (int p = 0; p < len; p++) begin
      case (mode)
        0:       iRGB = 15'(p);
        1:       iRGB = 15'h7FFF;
        default: iRGB = 15'($urandom);
      endcase
      iHBLK = (p < hs + 8) || (p >= len - 12);
      iHSYN = !(p < hs);
      iVBLK = vb;
      iVSYN = vs;
      for (int k = 0; k < 4; k++) begin
        RESET = (p == rst_at) && (k == 1);
        tick();
      end
    end
    RESET = 1'b0;
  endtask

  initial begin
    RESET    = 1'b1;
    PCLK_EN  = 1'b0;
    DCLK_EN  = 1'b0;
    iRGB     = '0;
    iHBLK    = 1'b1;
    iVBLK    = 1'b0;
    iHSYN    = 1'b1;
    iVSYN    = 1'b1;
    SCANLINE = 1'b0;
    model_reset();
    repeat (4) tick();
    RESET = 1'b0;

    repeat (3) run_line(320, 32, 0, 0, 1, -1);

    SCANLINE = 1'b1;
    repeat (3) run_line(320, 32, 1, 0, 1, -1);
    SCANLINE = 1'b0;

    repeat (2) run_line(600, 40, 2, 0, 1, -1);
    run_line(320, 32, 2, 0, 1, -1);

    for (int i = 0; i < 6; i++)
      run_line(200, 20, 2, (i >= 3), (i != 4), -1);

    coin = 1'b1;
    repeat (3) run_line(300, 24, 2, 0, 1, -1);
    coin = 1'b0;

    run_line(320, 32, 0, 0, 1, 150);
    repeat (3) run_line(320, 32, 0, 0, 1, -1);

    SCANLINE = 1'b1;
    for (int i = 0; i < 5; i++)
      run_line(int'($urandom_range(100, 600)), int'($urandom_range(8, 70)),
               2, 0, 1, -1);
    SCANLINE = 1'b0;
    run_line(320, 32, 0, 0, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
